// File: rtl/interrupt_ack_sequencer_8259a_pkg.sv
// Shared 8259A definitions: acknowledge-sequence states and the byte helpers
// also used by the priority resolver (one-hot encode, byte rotations).
package kf8259_common_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ACK1,
    ACK1,
    WAIT_ACK2,
    ACK2
  } ack_state_t;

  // Index of the set bit of a one-hot byte; the lowest set bit wins if more than one is set.
  function automatic logic [2:0] encode(input logic [7:0] one_hot);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (one_hot[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [7:0] rotate_right(input logic [7:0] value, input logic [2:0] amount);
    logic [15:0] doubled;
    doubled = {value, value} >> amount;
    return doubled[7:0];
  endfunction

  function automatic logic [7:0] rotate_left(input logic [7:0] value, input logic [2:0] amount);
    logic [15:0] doubled;
    doubled = {value, value} << amount;
    return doubled[15:8];
  endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_8259a_if.sv
// CPU-side bus of the 8259A acknowledge sequencer: INT, INTA# and the vector byte.
// master = the sequencer (drives INT and the data bus), slave = the CPU side.
interface interrupt_ack_sequencer_8259a_if;
  logic       int_out;
  logic       interrupt_acknowledge_n;
  logic [7:0] data_out;
  logic       data_out_enable;

  modport master (
    output int_out,
    output data_out,
    output data_out_enable,
    input  interrupt_acknowledge_n
  );

  modport slave (
    input  int_out,
    input  data_out,
    input  data_out_enable,
    output interrupt_acknowledge_n
  );
endinterface

// File: rtl/interrupt_ack_sequencer_8259a_in_service_priority_select.sv
// Picks the highest-priority in-service level under the current rotation.
// Priority starts at (priority_rotate + 1) mod 8 and wraps; an empty ISR gives 0.
module in_service_priority_select
  import kf8259_common_pkg::*;
(
  input  logic [7:0] in_service_register,
  input  logic [2:0] priority_rotate,
  output logic [7:0] highest_level_in_service
);

  logic [2:0] amount;
  logic [7:0] rotated;
  logic [7:0] lowest;

  // Normalise so the highest-priority level sits at bit 0, keep the lowest set bit, undo the rotation.
  always_comb begin
    amount                   = priority_rotate + 3'd1;
    rotated                  = rotate_right(in_service_register, amount);
    lowest                   = rotated & (~rotated + 8'd1);
    highest_level_in_service = rotate_left(lowest, amount);
  end

endmodule

// File: rtl/interrupt_ack_sequencer_8259a.sv
// 8086-mode INTA# handshake for the 8259A: raises INT, latches the acknowledged
// level on the first INTA# pulse, drives the vector on the second, and owns the ISR.
// Optional feature macro: INTA_TIMEOUT_EN (aborts a missing second INTA# pulse).
module interrupt_ack_sequencer_8259a
  import kf8259_common_pkg::*;
#(
  parameter int         ACK_TIMEOUT    = 256,
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  interrupt_ack_sequencer_8259a_if.master       bus,
  input  logic [7:0]                            interrupt,
  input  logic [2:0]                            priority_rotate,
  input  logic                                  auto_eoi_config,
  input  logic [7:0]                            end_of_interrupt,
  input  logic [4:0]                            interrupt_vector_base,
  output logic [7:0]                            clear_interrupt_request,
  output logic [7:0]                            in_service_register,
  output logic [7:0]                            highest_level_in_service,
  output logic                                  ack_timeout
);

  ack_state_t state, state_next;
  logic       inta_prev;
  logic       inta_fall, inta_rise;
  logic       take_ack1, finish_ack2, timeout_hit;
  logic [2:0] level;
  logic       spurious;
  logic [7:0] isr_next;
  logic [7:0] request_one_hot;

  assign inta_fall       = inta_prev & ~bus.interrupt_acknowledge_n;
  assign inta_rise       = ~inta_prev & bus.interrupt_acknowledge_n;
  assign request_one_hot = 8'b1 << encode(interrupt);

`ifdef INTA_TIMEOUT_EN
  localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  logic [CNT_W-1:0] timeout_count;

  // Counts clocks spent in WAIT_ACK2; restarts from zero on every entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                timeout_count <= '0;
    else if (state != WAIT_ACK2) timeout_count <= '0;
    else                         timeout_count <= timeout_count + 1'b1;
  end

  // One-cycle abort strobe when the second INTA# pulse never arrives.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ack_timeout <= 1'b0;
    else          ack_timeout <= timeout_hit;
  end
`else
  assign ack_timeout = 1'b0;
`endif

  // State register plus the INTA# history used for edge detection.
  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      inta_prev <= 1'b1;
    end else begin
      state     <= state_next;
      inta_prev <= bus.interrupt_acknowledge_n;
    end
  end

  // Next-state logic and the strobes that drive the level latch and ISR.
  // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    state_next  = state;
    take_ack1   = 1'b0;
    finish_ack2 = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE:      if (interrupt != 8'h00) state_next = WAIT_ACK1;
      WAIT_ACK1: if (inta_fall) begin
                   state_next = ACK1;
                   take_ack1  = 1'b1;
                 end
      ACK1:      if (inta_rise) state_next = WAIT_ACK2;
      WAIT_ACK2: begin
                   if (inta_fall) state_next = ACK2;
`ifdef INTA_TIMEOUT_EN
                   else if (timeout_count == CNT_W'(ACK_TIMEOUT - 1)) begin
                     state_next  = IDLE;
                     timeout_hit = 1'b1;
                   end
`endif
                 end
      ACK2:      if (inta_rise) begin
                   state_next  = IDLE;
                   finish_ack2 = 1'b1;
                 end
      default:   state_next = IDLE;
    endcase
  end

  // ISR next value: EOI clears first, then the acknowledge set (set wins), AEOI clear at the end of ACK2.
  always_comb begin
    isr_next = in_service_register & ~end_of_interrupt;
    if (take_ack1 && interrupt != 8'h00)
      isr_next = isr_next | request_one_hot;
    if (finish_ack2 && auto_eoi_config && !spurious)
      isr_next = isr_next & ~(8'b1 << level);
  end

  // Level latch, ISR and the one-cycle IRR clear pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level                   <= 3'd0;
      spurious                <= 1'b0;
      in_service_register     <= 8'h00;
      clear_interrupt_request <= 8'h00;
    end else begin
      in_service_register     <= isr_next;
      clear_interrupt_request <= (take_ack1 && interrupt != 8'h00) ? request_one_hot : 8'h00;
      if (take_ack1) begin
        level    <= (interrupt != 8'h00) ? encode(interrupt) : SPURIOUS_LEVEL;
        spurious <= (interrupt == 8'h00);
      end
    end
  end

  // CPU-side outputs follow the registered state.
  always_comb begin
    bus.int_out         = (state == WAIT_ACK1);
    bus.data_out_enable = (state == ACK2);
    bus.data_out        = (state == ACK2) ? {interrupt_vector_base, level} : 8'h00;
  end

  in_service_priority_select u_priority_select (
    .in_service_register      (in_service_register),
    .priority_rotate          (priority_rotate),
    .highest_level_in_service (highest_level_in_service)
  );

endmodule
